// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Stall/flush sequencer for the 5-stage LC-3b pipeline. It inserts
//   bubbles for load-use hazards that forwarding cannot cover, freezes the
//   pipeline while instruction or data memory is busy, and flushes the
//   younger stages when a branch resolves taken in MEM. It also keeps
//   saturating stall and flush counters.
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   id_*                           ID-stage source operand usage
//   ex_memread/regwrite/destreg    EX-stage load destination
//   imem_req/resp, dmem_req/resp   memory handshake (wait = req & !resp)
//   br_taken_mem, br_target        taken branch resolved in MEM
//   pc_load, pc_redirect_sel/pc_redirect   PC control
//   *_load, idex_bubble, flush_*   pipeline register control
//   stall_cycles, flush_events     performance counters
module pipeline_hazard_controller #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_srcA,
  input  logic [2:0]       id_srcB,
  input  logic             id_usesA,
  input  logic             id_usesB,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [2:0]       ex_destreg,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_taken_mem,
  input  logic [15:0]      br_target,
  output logic             pc_load,
  output logic             pc_redirect_sel,
  output logic [15:0]      pc_redirect,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_LU_HOLD = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam logic [1:0]       LU_INIT = 2'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  state, state_nxt;
  logic [15:0] tgt_q, tgt_nxt;
  logic [1:0]  bcnt, bcnt_nxt;
  logic        flush_hit;

  logic imem_wait, dmem_wait, load_use;

  assign imem_wait = imem_req & ~imem_resp;
  assign dmem_wait = dmem_req & ~dmem_resp;
  // R0 is compared too: a load into R0 still has to stall a reader of R0.
  assign load_use  = id_valid & ex_memread & ex_regwrite &
                     ((id_usesA & (id_srcA == ex_destreg)) |
                      (id_usesB & (id_srcB == ex_destreg)));

  always_comb begin
    pc_load         = 1'b1;
    pc_redirect_sel = 1'b0;
    pc_redirect     = br_target;
    ifid_load       = 1'b1;
    idex_load       = 1'b1;
    exmem_load      = 1'b1;
    memwb_load      = 1'b1;
    idex_bubble     = 1'b0;
    flush_ifid      = 1'b0;
    flush_idex      = 1'b0;
    flush_exmem     = 1'b0;
    state_nxt       = state;
    tgt_nxt         = tgt_q;
    bcnt_nxt        = bcnt;
    flush_hit       = 1'b0;

    if (reset) begin
      {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
      {flush_ifid, flush_idex, flush_exmem} = '1;
    end else begin
      case (state)
        S_RUN, S_LU_HOLD: begin
          if (dmem_wait) begin
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
          end else if (br_taken_mem) begin
            // Younger stages are wrong-path; any pending bubbles die with them.
            {flush_ifid, flush_idex, flush_exmem} = '1;
            flush_hit = 1'b1;
            bcnt_nxt  = 2'd0;
            if (imem_wait) begin
              // Fetch in flight: hold the target until the stale fetch returns.
              pc_load   = 1'b0;
              tgt_nxt   = br_target;
              state_nxt = S_DRAIN;
            end else begin
              pc_redirect_sel = 1'b1;
              state_nxt       = S_RUN;
            end
          end else if (imem_wait) begin
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
          end else if (state == S_LU_HOLD) begin
            pc_load     = 1'b0;
            ifid_load   = 1'b0;
            idex_bubble = 1'b1;
            bcnt_nxt    = bcnt - 2'd1;
            if (bcnt == 2'd1) state_nxt = S_RUN;
          end else if (load_use) begin
            pc_load     = 1'b0;
            ifid_load   = 1'b0;
            idex_bubble = 1'b1;
            if (LU_BUBBLES > 1) begin
              bcnt_nxt  = LU_INIT;
              state_nxt = S_LU_HOLD;
            end
          end
        end
        S_DRAIN: begin
          {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
          pc_redirect = tgt_q;
          if (imem_resp) begin
            // The returning instruction is from the wrong path; drop it.
            pc_load         = 1'b1;
            pc_redirect_sel = 1'b1;
            ifid_load       = 1'b1;
            flush_ifid      = 1'b1;
            state_nxt       = S_RUN;
          end
        end
        default: begin
          {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '0;
          state_nxt = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      tgt_q        <= 16'h0000;
      bcnt         <= 2'd0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_nxt;
      tgt_q <= tgt_nxt;
      bcnt  <= bcnt_nxt;
      if (!pc_load && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_ONE;
      if (flush_hit && !(&flush_events)) flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 0, id_usesA = 0, id_usesB = 0;
  logic [2:0]  id_srcA = 0, id_srcB = 0, ex_destreg = 0;
  logic        ex_memread = 0, ex_regwrite = 0;
  logic        imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
  logic        br_taken_mem = 0;
  logic [15:0] br_target = 0;

  logic        pc_load [2], pc_redirect_sel [2], ifid_load [2], idex_load [2];
  logic        exmem_load [2], memwb_load [2], idex_bubble [2];
  logic        flush_ifid [2], flush_idex [2], flush_exmem [2];
  logic [15:0] pc_redirect [2], stall_cycles [2], flush_events [2];
  logic [9:0]  act [2];

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.LU_BUBBLES(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_srcA(id_srcA), .id_srcB(id_srcB),
    .id_usesA(id_usesA), .id_usesB(id_usesB), .ex_memread(ex_memread),
    .ex_regwrite(ex_regwrite), .ex_destreg(ex_destreg), .imem_req(imem_req),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .br_taken_mem(br_taken_mem), .br_target(br_target), .pc_load(pc_load[0]),
    .pc_redirect_sel(pc_redirect_sel[0]), .pc_redirect(pc_redirect[0]),
    .ifid_load(ifid_load[0]), .idex_load(idex_load[0]), .exmem_load(exmem_load[0]),
    .memwb_load(memwb_load[0]), .idex_bubble(idex_bubble[0]), .flush_ifid(flush_ifid[0]),
    .flush_idex(flush_idex[0]), .flush_exmem(flush_exmem[0]),
    .stall_cycles(stall_cycles[0]), .flush_events(flush_events[0]));

  pipeline_hazard_controller #(.LU_BUBBLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_srcA(id_srcA), .id_srcB(id_srcB),
    .id_usesA(id_usesA), .id_usesB(id_usesB), .ex_memread(ex_memread),
    .ex_regwrite(ex_regwrite), .ex_destreg(ex_destreg), .imem_req(imem_req),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .br_taken_mem(br_taken_mem), .br_target(br_target), .pc_load(pc_load[1]),
    .pc_redirect_sel(pc_redirect_sel[1]), .pc_redirect(pc_redirect[1]),
    .ifid_load(ifid_load[1]), .idex_load(idex_load[1]), .exmem_load(exmem_load[1]),
    .memwb_load(memwb_load[1]), .idex_bubble(idex_bubble[1]), .flush_ifid(flush_ifid[1]),
    .flush_idex(flush_idex[1]), .flush_exmem(flush_exmem[1]),
    .stall_cycles(stall_cycles[1]), .flush_events(flush_events[1]));

  // {pc_load, sel, ifid, idex, exmem, memwb, bubble, flush_ifid, flush_idex, flush_exmem}
  always_comb
    for (int k = 0; k < 2; k++)
      act[k] = {pc_load[k], pc_redirect_sel[k], ifid_load[k], idex_load[k], exmem_load[k],
                memwb_load[k], idex_bubble[k], flush_ifid[k], flush_idex[k], flush_exmem[k]};

  localparam logic [9:0] C_DEF = 10'b1011110000;
  localparam logic [9:0] C_BUB = 10'b0001111000;
  localparam logic [9:0] C_FRZ = 10'b0000000000;
  localparam logic [9:0] C_RST = 10'b0000000111;
  localparam logic [9:0] C_BR  = 10'b1111110111;
  localparam logic [9:0] C_BRW = 10'b0011110111;
  localparam logic [9:0] C_DRN = 10'b1110000100;

  int passed = 0, total = 0;

  // Reference model: a pending-redirect flag, a remaining-bubble count and
  // plain integer counters, one set per DUT (0: 1 bubble, 1: 3 bubbles).
  typedef struct packed { logic [9:0] ctl; logic [15:0] redir; logic redir_valid; } exp_t;
  bit          m_drain [2];
  logic [15:0] m_tgt [2];
  int          m_left [2], m_stall [2], m_flush [2];

  function automatic bit f_iw(); return imem_req && !imem_resp; endfunction
  function automatic bit f_dw(); return dmem_req && !dmem_resp; endfunction
  function automatic bit f_lu();
    return id_valid && ex_memread && ex_regwrite &&
           ((id_usesA && id_srcA == ex_destreg) || (id_usesB && id_srcB == ex_destreg));
  endfunction

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.redir = br_target;
    e.redir_valid = 1'b0;
    if (reset) e.ctl = C_RST;
    else if (m_drain[k]) begin
      e.redir = m_tgt[k];
      e.redir_valid = 1'b1;
      e.ctl = imem_resp ? C_DRN : C_FRZ;
    end else if (f_dw()) e.ctl = C_FRZ;
    else if (br_taken_mem) begin
      e.ctl = f_iw() ? C_BRW : C_BR;
      e.redir_valid = !f_iw();
    end else if (f_iw()) e.ctl = C_FRZ;
    else if (m_left[k] > 0 || f_lu()) e.ctl = C_BUB;
    else e.ctl = C_DEF;
    return e;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = model_out(k);
      if (reset) begin
        m_drain[k] = 0; m_tgt[k] = 16'h0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (!e.ctl[9] && m_stall[k] < 65535) m_stall[k]++;
        if (m_drain[k]) begin
          if (imem_resp) m_drain[k] = 0;
        end else if (f_dw()) begin
        end else if (br_taken_mem) begin
          if (m_flush[k] < 65535) m_flush[k]++;
          m_left[k] = 0;
          if (f_iw()) begin m_drain[k] = 1; m_tgt[k] = br_target; end
        end else if (f_iw()) begin
        end else if (m_left[k] > 0) m_left[k]--;
        else if (f_lu()) m_left[k] = (k == 0) ? 0 : 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 0; id_usesA = 0; id_usesB = 0; id_srcA = 0; id_srcB = 0;
    ex_memread = 0; ex_regwrite = 0; ex_destreg = 0;
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    br_taken_mem = 0; br_target = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic set_hazard();
    id_valid = 1; id_srcA = 3; id_usesA = 1; id_srcB = 5; id_usesB = 0;
    ex_memread = 1; ex_regwrite = 1; ex_destreg = 3;
  endtask

  task automatic test_reset();
    idle(); reset = 1; br_taken_mem = 1; br_target = 16'hBEEF; set_hazard();
    @(negedge clk);
    total++; if (act[0] !== C_RST) $display("FAIL reset_ctl: got %b expected %b", act[0], C_RST); else passed++;
    tick(); idle(); reset = 0;
    @(negedge clk);
    total++; if (act[0] !== C_DEF) $display("FAIL post_reset_ctl: got %b expected %b", act[0], C_DEF); else passed++;
    total++; if (stall_cycles[0] !== 16'd0 || flush_events[0] !== 16'd0)
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles[0], flush_events[0]); else passed++;
  endtask

  task automatic test_load_use();
    do_reset(); set_hazard();
    @(negedge clk);
    total++; if (act[0] !== C_BUB) $display("FAIL lu1_bubble: got %b expected %b", act[0], C_BUB); else passed++;
    tick(); idle();
    @(negedge clk);
    total++; if (act[0] !== C_DEF) $display("FAIL lu1_after: got %b expected %b", act[0], C_DEF); else passed++;
    total++; if (stall_cycles[0] !== 16'd1) $display("FAIL lu1_stall: got %0d expected 1", stall_cycles[0]); else passed++;
    total++; if (act[1] !== C_BUB) $display("FAIL lu3_bubble2: got %b expected %b", act[1], C_BUB); else passed++;
    tick();
    @(negedge clk);
    total++; if (act[1] !== C_BUB) $display("FAIL lu3_bubble3: got %b expected %b", act[1], C_BUB); else passed++;
    tick();
    @(negedge clk);
    total++; if (act[1] !== C_DEF) $display("FAIL lu3_after: got %b expected %b", act[1], C_DEF); else passed++;
    total++; if (stall_cycles[1] !== 16'd3) $display("FAIL lu3_stall: got %0d expected 3", stall_cycles[1]); else passed++;
  endtask

  task automatic test_dmem_wait();
    do_reset(); set_hazard(); dmem_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (act[0] !== C_FRZ) $display("FAIL dmem_freeze%0d: got %b expected %b", i, act[0], C_FRZ); else passed++;
      tick();
    end
    dmem_resp = 1;
    @(negedge clk);
    total++; if (act[0] !== C_BUB) $display("FAIL dmem_then_bubble: got %b expected %b", act[0], C_BUB); else passed++;
    tick(); idle();
    @(negedge clk);
    total++; if (stall_cycles[0] !== 16'd5) $display("FAIL dmem_stall: got %0d expected 5", stall_cycles[0]); else passed++;
  endtask

  task automatic test_branch();
    do_reset(); br_taken_mem = 1; br_target = 16'h3000;
    @(negedge clk);
    total++; if (act[0] !== C_BR) $display("FAIL br_ctl: got %b expected %b", act[0], C_BR); else passed++;
    total++; if (pc_redirect[0] !== 16'h3000) $display("FAIL br_target: got %h expected 3000", pc_redirect[0]); else passed++;
    tick(); idle();
    @(negedge clk);
    total++; if (flush_events[0] !== 16'd1 || stall_cycles[0] !== 16'd0)
      $display("FAIL br_counters: got %0d/%0d expected 1/0", flush_events[0], stall_cycles[0]); else passed++;
  endtask

  task automatic test_branch_drain();
    do_reset(); br_taken_mem = 1; br_target = 16'h1234; imem_req = 1;
    @(negedge clk);
    total++; if (act[0] !== C_BRW) $display("FAIL brw_ctl: got %b expected %b", act[0], C_BRW); else passed++;
    tick(); br_taken_mem = 0; br_target = 16'h0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (act[0] !== C_FRZ || pc_redirect[0] !== 16'h1234)
        $display("FAIL drain%0d: got %b/%h expected %b/1234", i, act[0], pc_redirect[0], C_FRZ); else passed++;
      tick();
    end
    imem_resp = 1;
    @(negedge clk);
    total++; if (act[0] !== C_DRN || pc_redirect[0] !== 16'h1234)
      $display("FAIL drain_resp: got %b/%h expected %b/1234", act[0], pc_redirect[0], C_DRN); else passed++;
    tick(); idle();
    @(negedge clk);
    total++; if (act[0] !== C_DEF) $display("FAIL drain_exit: got %b expected %b", act[0], C_DEF); else passed++;
    total++; if (stall_cycles[0] !== 16'd4 || flush_events[0] !== 16'd1)
      $display("FAIL drain_counters: got %0d/%0d expected 4/1", stall_cycles[0], flush_events[0]); else passed++;
  endtask

  task automatic test_reset_in_drain();
    do_reset(); br_taken_mem = 1; br_target = 16'h5555; imem_req = 1;
    tick(); br_taken_mem = 0;
    tick(); reset = 1;
    @(negedge clk);
    total++; if (act[0] !== C_RST) $display("FAIL rst_drain_ctl: got %b expected %b", act[0], C_RST); else passed++;
    tick(); reset = 0; imem_req = 1; imem_resp = 1;
    @(negedge clk);
    total++; if (act[0] !== C_DEF) $display("FAIL rst_drain_run: got %b expected %b", act[0], C_DEF); else passed++;
    total++; if (stall_cycles[0] !== 16'd0 || flush_events[0] !== 16'd0)
      $display("FAIL rst_drain_counters: got %0d/%0d expected 0/0", stall_cycles[0], flush_events[0]); else passed++;
    tick(); idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      id_valid     = $urandom_range(0, 3) != 0;
      id_srcA      = 3'($urandom_range(0, 3));
      id_srcB      = 3'($urandom_range(0, 3));
      id_usesA     = $urandom_range(0, 1);
      id_usesB     = $urandom_range(0, 1);
      ex_memread   = $urandom_range(0, 1);
      ex_regwrite  = $urandom_range(0, 3) != 0;
      ex_destreg   = 3'($urandom_range(0, 3));
      imem_req     = $urandom_range(0, 1);
      imem_resp    = $urandom_range(0, 1);
      dmem_req     = $urandom_range(0, 3) == 0;
      dmem_resp    = $urandom_range(0, 1);
      br_taken_mem = $urandom_range(0, 9) == 0;
      br_target    = 16'($urandom);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e = model_out(k);
        total++;
        if (act[k] !== e.ctl || (e.redir_valid && pc_redirect[k] !== e.redir) ||
            stall_cycles[k] !== 16'(m_stall[k]) || flush_events[k] !== 16'(m_flush[k]))
          $display("FAIL rand[%0d] dut%0d: got %b/%h/%0d/%0d expected %b/%h/%0d/%0d", n, k,
                   act[k], pc_redirect[k], stall_cycles[k], flush_events[k],
                   e.ctl, e.redir, m_stall[k], m_flush[k]);
        else passed++;
      end
      tick();
    end
    idle(); reset = 0;
  endtask

  initial begin
    idle();
    tick();
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_branch();
    test_branch_drain();
    test_reset_in_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF/ID/EX/MEM/WB). Detects load-use hazards that the forwarding path cannot cover, freezes the pipeline on instruction or data memory waits, and flushes younger stages on a taken branch resolved in MEM. Drives every pipeline-register load/flush enable and the PC redirect select, and keeps stall/flush performance counters.

Parameters:
LU_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_srcA  in  3  ID source register A
id_srcB  in  3  ID source register B
id_usesA  in  1  ID instruction reads srcA
id_usesB  in  1  ID instruction reads srcB
ex_memread  in  1  EX instruction is a load (LDR/LDB/LDI)
ex_regwrite  in  1  EX instruction writes a register
ex_destreg  in  3  EX destination register
imem_req  in  1  fetch outstanding
imem_resp  in  1  fetch complete this cycle
dmem_req  in  1  MEM-stage access outstanding
dmem_resp  in  1  MEM-stage access complete this cycle
br_taken_mem  in  1  branch/jump in MEM resolved taken
br_target  in  16  redirect address from MEM
pc_load  out  1  PC register load enable
pc_redirect_sel  out  1  PC mux selects pc_redirect
pc_redirect  out  16  redirect address to PC mux
ifid_load, idex_load, exmem_load, memwb_load  out  1 each  stage-register load enables
idex_bubble  out  1  load NOP into ID/EX
flush_ifid, flush_idex, flush_exmem  out  1 each  load NOP into that stage register
stall_cycles  out  CNT_W  cycles with pc_load=0 (saturating)
flush_events  out  CNT_W  taken-branch flushes (saturating)

Behaviour:
- Definitions: imem_wait = imem_req & !imem_resp; dmem_wait = dmem_req & !dmem_resp; load_use = id_valid & ex_memread & ex_regwrite & ((id_usesA & id_srcA==ex_destreg) | (id_usesB & id_srcB==ex_destreg)); all 8 registers including R0 compared.
- Outputs are combinational from state+inputs; state, latched target, bubble counter, perf counters are registered.
- Default (no event): all loads 1, flushes 0, idex_bubble 0, pc_redirect_sel 0.
- States: RUN, LU_HOLD, DRAIN.
- RUN, priority highest first:
  1. dmem_wait: all loads 0; stay RUN.
  2. br_taken_mem: memwb_load=1, exmem/idex/ifid loads 1 with flush_exmem/flush_idex/flush_ifid=1; flush_events++. If !imem_wait: pc_load=1, pc_redirect_sel=1, pc_redirect=br_target, stay RUN. If imem_wait: pc_load=0, latch br_target -> DRAIN.
  3. imem_wait: all loads 0; stay RUN.
  4. load_use: pc_load=0, ifid_load=0, idex_load=1 with idex_bubble=1, exmem/memwb load 1. LU_BUBBLES=1 -> stay RUN; else counter=LU_BUBBLES-1 -> LU_HOLD.
- LU_HOLD: dmem_wait/imem_wait freeze as above without decrementing; otherwise repeat bubble pattern, decrement; at 0 -> RUN. br_taken_mem in LU_HOLD handled exactly as in RUN and cancels remaining bubbles.
- DRAIN: all loads 0, pc_redirect=latched target. On imem_resp: pc_load=1, pc_redirect_sel=1, ifid_load=1 with flush_ifid=1 (returned instruction discarded) -> RUN. br_taken_mem and load_use ignored in DRAIN (pipeline already flushed).
- stall_cycles increments every cycle pc_load=0 (outside reset); both counters saturate at all-ones.
- Reset (any state, mid-stall or mid-drain): next state RUN, counters 0, latched target 0x0000, bubble counter 0. While reset=1: all loads 0, flush_* 1, pc_redirect_sel 0.

Test Plan:
- LDR R3 in EX, ADD in ID reading R3 (usesA), no waits -> one cycle pc_load=0, ifid_load=0, idex_bubble=1; next cycle defaults; stall_cycles=1.
- Same hazard, LU_BUBBLES=3 -> three consecutive bubble cycles, then RUN; stall_cycles=3.
- dmem_req=1 for 4 cycles then dmem_resp=1 concurrent with load_use -> 4 cycles all loads 0, then bubble cycle.
- br_taken_mem=1, br_target=0x3000, imem idle -> same cycle pc_redirect_sel=1, pc_redirect=0x3000, three flushes=1; flush_events=1.
- br_taken_mem=1, br_target=0x1234, imem_wait 3 more cycles -> DRAIN 3 cycles all loads 0; on imem_resp pc_load=1, pc_redirect=0x1234, flush_ifid=1.
- reset asserted in DRAIN -> next cycle RUN, counters 0, no redirect issued.
